// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix MAC engine: FSM state encoding,
// index-width helper and the signed saturation function used by the output stage.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_ADD   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Widest sum the saturation helper accepts; callers sign-extend into it.
    localparam int SAT_MAXW = 256;

    // Index width for a dimension, never narrower than one bit.
    function automatic int clog2_floor1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Clamp a signed value into the w-bit two's complement range.
    function automatic logic signed [SAT_MAXW-1:0] saturate(
        input logic signed [SAT_MAXW-1:0] v,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed WxW multiply into an ACC_W accumulator, plus the optional R add and
// saturate/truncate output stage; result is combinational from the accumulator.
module mac_unit
    import matrix_pkg::*;
#(
    parameter int W     = 32,
    parameter int ACC_W = 2 * W + 4,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         mac_en,
    input  logic         add_r,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] r,
    output logic [W-1:0] res
);

    logic signed [2*W-1:0]      prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    r_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    sum;
    logic signed [SAT_MAXW-1:0] sat_in;

    assign prod     = (2*W)'($signed(a)) * (2*W)'($signed(b));
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    assign r_ext    = {{(ACC_W-W){r[W-1]}}, r};

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ACC_W leaves headroom for N full products plus R, so sum never wraps.
    assign sum    = acc_q + (add_r ? r_ext : '0);
    assign sat_in = {{(SAT_MAXW-ACC_W){sum[ACC_W-1]}}, sum};
    assign res    = (SAT != 0) ? W'(saturate(sat_in, W)) : sum[W-1:0];

endmodule

// File: rtl/matrix_mac_engine.sv
// Z = A*B (optionally R + A*B), one element per N+2 cycles, operands fetched by index.
// Each result is held on z_out/z_stb until z_ack; the sequencer stalls in WRITE meanwhile.
module matrix_mac_engine
    import matrix_pkg::*;
#(
    parameter int M   = 4,
    parameter int N   = 8,
    parameter int P   = 4,
    parameter int W   = 32,
    parameter int SAT = 1,
    localparam int MI    = clog2_floor1(M),
    localparam int NI    = clog2_floor1(N),
    localparam int PI    = clog2_floor1(P),
    localparam int ACC_W = 2 * W + NI + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          accumulate,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic [W-1:0]  current_element,
    input  logic          z_ack,
    output logic [MI-1:0] a_i,
    output logic [NI-1:0] a_j,
    output logic [NI-1:0] b_i,
    output logic [PI-1:0] b_j,
    output logic [MI-1:0] z_i,
    output logic [PI-1:0] z_j,
    output logic [W-1:0]  z_out,
    output logic          z_stb,
    output logic          done
);

    state_t        state_q;
    logic          mode_q;
    logic [MI-1:0] row_q;
    logic [PI-1:0] col_q;
    logic [NI-1:0] k_q;
    logic [W-1:0]  z_out_q;
    logic          z_stb_q;
    logic          done_q;

    logic          last_k;
    logic          last_col;
    logic          last_elem;
    logic          hs;
    logic          mac_clr;
    logic          mac_en;
    logic [W-1:0]  mac_res;

    assign last_k    = (k_q == NI'(N - 1));
    assign last_col  = (col_q == PI'(P - 1));
    assign last_elem = last_col && (row_q == MI'(M - 1));
    assign hs        = (state_q == ST_WRITE) && z_stb_q && z_ack;
    assign mac_en    = (state_q == ST_MAC);
    assign mac_clr   = ((state_q == ST_IDLE) && start) || hs;

    mac_unit #(
        .W    (W),
        .ACC_W(ACC_W),
        .SAT  (SAT)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (mac_clr),
        .mac_en(mac_en),
        .add_r (mode_q),
        .a     (a_in),
        .b     (b_in),
        .r     (current_element),
        .res   (mac_res)
    );

    // Indices reset to 0 instead of overflowing so unused index bits stay 0
    // when a dimension is 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            z_out_q <= '0;
            z_stb_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= accumulate;
                        row_q   <= '0;
                        col_q   <= '0;
                        k_q     <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last_k) begin
                        k_q     <= '0;
                        state_q <= ST_ADD;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_ADD: begin
                    z_out_q <= mac_res;
                    z_stb_q <= 1'b1;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (hs) begin
                        z_stb_q <= 1'b0;
                        k_q     <= '0;
                        if (last_elem) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            if (last_col) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            state_q <= ST_MAC;
                        end
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_i   = row_q;
    assign a_j   = k_q;
    assign b_i   = k_q;
    assign b_j   = col_q;
    assign z_i   = row_q;
    assign z_j   = col_q;
    assign z_out = z_out_q;
    assign z_stb = z_stb_q;
    assign done  = done_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench: scoreboard of expected Z elements for a 2x2x2 engine, plus
// small saturation/truncation/signed instances.
module tb_matrix_mac_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic rst_n;

    // Main 2x2x2 engine
    logic       start, accumulate, z_ack;
    logic [7:0] a_in, b_in, cur, z_out;
    logic       a_i, a_j, b_i, b_j, z_i, z_j, z_stb, done;

    logic signed [7:0] amem [0:1][0:1];
    logic signed [7:0] bmem [0:1][0:1];
    logic signed [7:0] rmem [0:1][0:1];

    assign a_in = amem[a_i][a_j];
    assign b_in = bmem[b_i][b_j];
    assign cur  = rmem[z_i][z_j];

    matrix_mac_engine #(.M(2), .N(2), .P(2), .W(8), .SAT(1)) u_dut (
        .clk(clk), .rst(rst_n), .start(start), .accumulate(accumulate),
        .a_in(a_in), .b_in(b_in), .current_element(cur), .z_ack(z_ack),
        .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .z_i(z_i), .z_j(z_j),
        .z_out(z_out), .z_stb(z_stb), .done(done)
    );

    // 1x2x1 engines, saturating and truncating, all operands 127
    logic       start2, ack2, acc_off;
    logic [7:0] op127, zero8;
    logic       s_a_i, s_a_j, s_b_i, s_b_j, s_z_i, s_z_j, s_stb, s_done;
    logic       t_a_i, t_a_j, t_b_i, t_b_j, t_z_i, t_z_j, t_stb, t_done;
    logic [7:0] s_z_out, t_z_out;

    matrix_mac_engine #(.M(1), .N(2), .P(1), .W(8), .SAT(1)) u_sat (
        .clk(clk), .rst(rst_n), .start(start2), .accumulate(acc_off),
        .a_in(op127), .b_in(op127), .current_element(zero8), .z_ack(ack2),
        .a_i(s_a_i), .a_j(s_a_j), .b_i(s_b_i), .b_j(s_b_j), .z_i(s_z_i), .z_j(s_z_j),
        .z_out(s_z_out), .z_stb(s_stb), .done(s_done)
    );

    matrix_mac_engine #(.M(1), .N(2), .P(1), .W(8), .SAT(0)) u_trn (
        .clk(clk), .rst(rst_n), .start(start2), .accumulate(acc_off),
        .a_in(op127), .b_in(op127), .current_element(zero8), .z_ack(ack2),
        .a_i(t_a_i), .a_j(t_a_j), .b_i(t_b_i), .b_j(t_b_j), .z_i(t_z_i), .z_j(t_z_j),
        .z_out(t_z_out), .z_stb(t_stb), .done(t_done)
    );

    // 1x1x1 signed engine: -3 * 5
    logic       start3, ack3;
    logic [7:0] op_m3, op_5;
    logic       o_a_i, o_a_j, o_b_i, o_b_j, o_z_i, o_z_j, o_stb, o_done;
    logic [7:0] o_z_out;

    matrix_mac_engine #(.M(1), .N(1), .P(1), .W(8), .SAT(1)) u_one (
        .clk(clk), .rst(rst_n), .start(start3), .accumulate(acc_off),
        .a_in(op_m3), .b_in(op_5), .current_element(zero8), .z_ack(ack3),
        .a_i(o_a_i), .a_j(o_a_j), .b_i(o_b_i), .b_j(o_b_j), .z_i(o_z_i), .z_j(o_z_j),
        .z_out(o_z_out), .z_stb(o_stb), .done(o_done)
    );

    typedef struct packed {
        logic       i;
        logic       j;
        logic [7:0] v;
    } exp_t;

    exp_t sbq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference element: integer dot product, optional R, clamp to 8 bits.
    function automatic logic [7:0] model(input int i, input int j, input bit acc);
        int s;
        s = 0;
        for (int k = 0; k < 2; k++) begin
            s += int'(amem[i][k]) * int'(bmem[k][j]);
        end
        if (acc) begin
            s += int'(rmem[i][j]);
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    task automatic start_job(input bit acc);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                e.i = 1'(i);
                e.j = 1'(j);
                e.v = model(i, j, acc);
                sbq.push_back(e);
            end
        end
        accumulate = acc;
        start      = 1'b1;
    endtask

    // Wait for one result, score it, hold for ack_delay-1 cycles, then ack.
    task automatic do_element(input int ack_delay, input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!z_stb && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stb_seen", {31'd0, z_stb}, 32'd1);
        if (!z_stb) return;
        chk("latency", cyc, exp_lat);
        chk("done_early", {31'd0, done}, 32'd0);
        if (sbq.size() == 0) begin
            chk("sb_nonempty", sbq.size(), 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk("z_idx", {30'd0, z_i, z_j}, {30'd0, e.i, e.j});
        chk("z_out", {24'd0, z_out}, {24'd0, e.v});
        for (int c = 1; c < ack_delay; c++) begin
            @(negedge clk);
            chk("hold", {21'd0, z_stb, z_i, z_j, z_out}, {21'd0, 1'b1, e.i, e.j, e.v});
        end
        z_ack = 1'b1;
        @(negedge clk);
        z_ack = 1'b0;
        chk("stb_drop", {31'd0, z_stb}, 32'd0);
    endtask

    task automatic finish_job();
        int cyc;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_set", {31'd0, done}, 32'd1);
        chk("sb_drained", sbq.size(), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("done_clr", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0; accumulate = 1'b0; z_ack = 1'b0;
        start2 = 1'b0; ack2 = 1'b0; start3 = 1'b0; ack3 = 1'b0;
        acc_off = 1'b0; zero8 = 8'd0; op127 = 8'd127; op_m3 = 8'hFD; op_5 = 8'd5;
        amem = '{'{8'sd1, 8'sd2}, '{8'sd3, 8'sd4}};
        bmem = '{'{8'sd5, 8'sd6}, '{8'sd7, 8'sd8}};
        rmem = '{'{8'sd10, 8'sd10}, '{8'sd10, 8'sd10}};
        repeat (2) @(negedge clk);
        chk("reset_state", {16'd0, z_stb, done, a_i, a_j, b_i, b_j, z_i, z_j, z_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain product, prompt acks
        start_job(1'b0);
        do_element(1, 4);
        do_element(1, 3);
        do_element(1, 3);
        do_element(1, 3);
        finish_job();

        // R + A*B, stray ack during MAC, 20-cycle withheld ack
        @(negedge clk);
        start_job(1'b1);
        do_element(1, 4);
        z_ack = 1'b1;
        @(negedge clk);
        z_ack = 1'b0;
        do_element(1, 2);
        do_element(21, 3);
        do_element(1, 3);
        finish_job();

        // Saturation vs truncation of 2*127*127
        start2 = 1'b1;
        cyc = 0;
        while (!s_stb && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_stb", {30'd0, s_stb, t_stb}, 32'd3);
        chk("sat_out", {24'd0, s_z_out}, 32'd127);
        chk("trunc_out", {24'd0, t_z_out}, 32'h02);
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        chk("sat_done", {30'd0, s_done, t_done}, 32'd3);
        start2 = 1'b0;
        @(negedge clk);
        chk("sat_done_clr", {30'd0, s_done, t_done}, 32'd0);

        // 1x1x1 signed product
        start3 = 1'b1;
        cyc = 0;
        while (!o_stb && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("one_latency", cyc, 32'd3);
        chk("one_out", {24'd0, o_z_out}, 32'h000000F1);
        chk("one_idx", {28'd0, o_a_i, o_a_j, o_z_i, o_z_j}, 32'd0);
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;
        chk("one_done", {30'd0, o_stb, o_done}, 32'd1);
        start3 = 1'b0;
        @(negedge clk);

        // Abort during MAC of element (1,0), then a clean rerun
        start_job(1'b0);
        do_element(1, 4);
        do_element(1, 3);
        @(negedge clk);
        chk("mid_row", {31'd0, a_i}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_state", {16'd0, z_stb, done, a_i, a_j, b_i, b_j, z_i, z_j, z_out}, 32'd0);
        sbq.delete();
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {30'd0, z_stb, done}, 32'd0);
        start_job(1'b0);
        do_element(1, 4);
        do_element(1, 3);
        do_element(1, 3);
        do_element(1, 3);
        finish_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
